// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// The block scans one digit per slot of DIV clock cycles. It drives active-low
// segment, decimal-point and digit-select lines. New display data is first
// captured into a pending register. It is moved into the displayed (shadow)
// register only at a frame boundary, so a frame never mixes old and new data.
// At the start of every slot, all digit selects are held off for BLANK cycles
// so the previous digit's segments do not ghost onto the next digit.
//
// Parameters
//   DIGITS : number of digits (1..16)
//   DIV    : clock cycles per digit slot (>= 2, > BLANK)
//   BLANK  : cycles at the start of each slot with all digits deselected
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   load       : capture value/digit_en/dp into the pending register
//   value      : hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   digit_en   : per-digit enable, 0 blanks segments and dp of that digit
//   dp         : per-digit decimal point request, 1 = lit
//   seg        : active-low segments, seg[6]=a .. seg[0]=g (registered)
//   seg_dp     : active-low decimal point (registered)
//   an         : active-low digit select, at most one bit low (registered)
//   frame_done : one-cycle pulse in the cycle after each frame boundary
//
// Build option
//   SEG_SCAN_LZS_EN : when defined, leading zeros are suppressed. A digit
//                     above digit 0 has its segments blanked when it and all
//                     higher digits hold 0. Its dp still follows dp/digit_en.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int DIGITS = 8,
  parameter int DIV    = 1000,
  parameter int BLANK  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = $clog2(DIV);
  // A single-digit build still needs a 1-bit index to keep the logic uniform.
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   en;
    logic [DIGITS-1:0]   dp;
  } disp_t;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  disp_t             pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  disp_t             shad_q, shad_d;
  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q, frame_done_d;

  logic              slot_end;
  logic              boundary;
  logic [3:0]        cur_nib;
  logic              cur_en;
  logic              cur_dp;
  logic              cur_supp;
  logic [DIGITS-1:0] supp;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_to_seg = 7'b0000001;
      4'h1:    hex_to_seg = 7'b1001111;
      4'h2:    hex_to_seg = 7'b0010010;
      4'h3:    hex_to_seg = 7'b0000110;
      4'h4:    hex_to_seg = 7'b1001100;
      4'h5:    hex_to_seg = 7'b0100100;
      4'h6:    hex_to_seg = 7'b0100000;
      4'h7:    hex_to_seg = 7'b0001111;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0000100;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b1100000;
      4'hC:    hex_to_seg = 7'b0110001;
      4'hD:    hex_to_seg = 7'b1000010;
      4'hE:    hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  assign slot_end = (cnt_q == CW'(DIV - 1));
  assign boundary = slot_end && (idx_q == IW'(DIGITS - 1));

  // Scan timing and the pending -> shadow transfer.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    shad_d   = shad_q;

    if (slot_end) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    // The shadow takes the pending contents as they were before this cycle.
    // A load in the boundary cycle therefore lands in pending and waits one
    // more frame.
    if (boundary && pend_v_q) begin
      shad_d   = pend_q;
      pend_v_d = 1'b0;
    end

    if (load) begin
      pend_d   = '{value: value, en: digit_en, dp: dp};
      pend_v_d = 1'b1;
    end
  end

  // Leading-zero suppression mask, built from the top digit downwards.
`ifdef SEG_SCAN_LZS_EN
  always_comb begin
    logic lead;
    lead = 1'b1;
    supp = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (shad_q.value[4*i +: 4] != 4'h0) lead = 1'b0;
      supp[i] = lead;
    end
  end
`else
  assign supp = '0;
`endif

  // Select the current digit's data and form the next output values.
  always_comb begin
    cur_nib  = 4'h0;
    cur_en   = 1'b0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    an_d     = '1;

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib  = shad_q.value[4*i +: 4];
        cur_en   = shad_q.en[i];
        cur_dp   = shad_q.dp[i];
        cur_supp = supp[i];
        // The anti-ghost window keeps every select off early in the slot.
        an_d[i]  = (int'(cnt_q) < BLANK);
      end
    end

    seg_d        = (cur_en && !cur_supp) ? hex_to_seg(cur_nib) : 7'b1111111;
    seg_dp_d     = ~(cur_en & cur_dp);
    frame_done_d = boundary;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  // NOTE: pending and shadow are reset too. They are small registers, not
  // storage arrays, and the display must come up blank with stale loads
  // dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      shad_q       <= '0;
      seg_q        <= 7'b1111111;
      seg_dp_q     <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      shad_q       <= shad_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Self-checking bench for seg_scan_ctrl with DIGITS=4, DIV=4, BLANK=1.
// A cycle model of the display pushes the expected outputs for every clock
// into a queue, and the outputs are popped and compared on the falling edge.
// Directed checks pin the documented timing and decode values.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BLANK  = 1;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] value    = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  dp       = '0;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .digit_en   (digit_en),
    .dp         (dp),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cyc %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Seven-segment table, active-low abcdefg.
  logic [6:0] lut [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int          m_cnt, m_idx;
  logic        m_pv;
  logic [15:0] m_pval, m_sval;
  logic [3:0]  m_pen, m_pdp, m_sen, m_sdp;

  function automatic exp_t model_out();
    exp_t e;
    int   nib;
    bit   supp;
    nib  = int'((m_sval >> (4 * m_idx)) & 16'h000F);
    supp = 1'b0;
`ifdef SEG_SCAN_LZS_EN
    // A digit is a leading zero when nothing at or above it is non-zero.
    supp = (m_idx > 0) && ((m_sval >> (4 * m_idx)) == 16'h0);
`endif
    e.seg = (m_sen[m_idx] && !supp) ? lut[nib] : 7'b1111111;
    e.dp  = !(m_sen[m_idx] && m_sdp[m_idx]);
    e.an  = (m_cnt < BLANK) ? 4'b1111 : ~(4'b0001 << m_idx);
    e.fd  = (m_cnt == DIV - 1) && (m_idx == DIGITS - 1);
    return e;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_idx  = 0;
    m_pv   = 1'b0;
    m_pval = '0; m_pen = '0; m_pdp = '0;
    m_sval = '0; m_sen = '0; m_sdp = '0;
    sb_q.delete();
    cyc = 0;
  endtask

  task automatic model_step();
    sb_q.push_back(model_out());
    if ((m_cnt == DIV - 1) && (m_idx == DIGITS - 1) && m_pv) begin
      m_sval = m_pval; m_sen = m_pen; m_sdp = m_pdp;
      m_pv   = 1'b0;
    end
    if (load) begin
      m_pval = value; m_pen = digit_en; m_pdp = dp;
      m_pv   = 1'b1;
    end
    if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % DIGITS;
    end else begin
      m_cnt = m_cnt + 1;
    end
    cyc = cyc + 1;
  endtask

  task automatic sb_compare();
    sb_e = sb_q.pop_front();
    check("sb_seg", seg, sb_e.seg);
    check("sb_dp", seg_dp, sb_e.dp);
    check("sb_an", an, sb_e.an);
    check("sb_fd", frame_done, sb_e.fd);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (rst_n && sb_q.size() > 0) sb_compare();
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
    value    = v;
    digit_en = e;
    dp       = d;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [6:0] s, input logic d, input logic [3:0] a);
    check({tag, "_seg"}, seg, s);
    check({tag, "_dp"}, seg_dp, d);
    check({tag, "_an"}, an, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [6:0] a5c3 [4] = '{7'b0000110, 7'b0110001, 7'b0100100, 7'b0001000};
  logic [6:0] lz_hi;

  initial begin
`ifdef SEG_SCAN_LZS_EN
    lz_hi = 7'b1111111;
`else
    lz_hi = 7'b0000001;
`endif
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out("rst", 7'b1111111, 1'b1, 4'b1111);
    check("rst_fd", frame_done, 1'b0);
    rst_n = 1'b1;

    // Idle after reset: blank segments, frame_done at cycle 16 and 32.
    // The test load in frame 2 is shown from the next boundary.
    for (int k = 1; k <= 32; k++) begin
      wait_cyc(k);
      check("idle_fd", frame_done, (k == 16) || (k == 32));
      check("idle_seg", seg, 7'b1111111);
      if (k == 20) drive_load(16'hA5C3, 4'b1111, 4'b0000);
    end

    // One frame of A5C3, digit by digit. A mid-frame load must not disturb it.
    for (int k = 33; k <= 48; k++) begin
      int slot;
      int c;
      wait_cyc(k);
      slot = (k - 33) / 4;
      c    = (k - 33) % 4;
      check_out("a5c3", a5c3[slot], 1'b1, (c == 0) ? 4'b1111 : ~(4'b0001 << slot));
      check("a5c3_fd", frame_done, k == 48);
      if (k == 40) drive_load(16'h1234, 4'b1111, 4'b0000);
    end

    // Mid-frame load shown next frame. A load in the boundary cycle waits a
    // frame behind the pending data that was already there.
    wait_cyc(50);  check("mid_new", seg, 7'b1001100);
    wait_cyc(56);  drive_load(16'h0F0F, 4'b1111, 4'b0000);
    wait_cyc(63);  drive_load(16'h5678, 4'b1111, 4'b0000);
    wait_cyc(66);  check("bnd_old_d0", seg, 7'b0111000);
    wait_cyc(70);  check("bnd_old_d1", seg, 7'b0000001);
    wait_cyc(82);  check("bnd_new_d0", seg, 7'b0000000);
    wait_cyc(86);  check("bnd_new_d1", seg, 7'b0001111);

    // Digit blanking and dp gating.
    wait_cyc(90);  drive_load(16'h8888, 4'b0101, 4'b0010);
    wait_cyc(98);  check_out("en_d0", 7'b0000000, 1'b1, 4'b1110);
    wait_cyc(102); check_out("en_d1", 7'b1111111, 1'b1, 4'b1101);
    wait_cyc(106); check_out("en_d2", 7'b0000000, 1'b1, 4'b1011);
    wait_cyc(110); check_out("en_d3", 7'b1111111, 1'b1, 4'b0111);

    // Leading zeros (blanked only when the suppression option is built in).
    wait_cyc(114); drive_load(16'h0070, 4'b1111, 4'b0000);
    wait_cyc(130); check("lz70_d0", seg, 7'b0000001);
    wait_cyc(134); check("lz70_d1", seg, 7'b0001111);
    wait_cyc(138); check("lz70_d2", seg, lz_hi);
    wait_cyc(142); check("lz70_d3", seg, lz_hi);
    wait_cyc(146); drive_load(16'h0000, 4'b1111, 4'b0100);
    wait_cyc(162); check("lz0_d0", seg, 7'b0000001);
    wait_cyc(166); check("lz0_d1", seg, lz_hi);
    wait_cyc(170); check_out("lz0_d2", lz_hi, 1'b0, 4'b1011);
    wait_cyc(174); check("lz0_d3", seg, lz_hi);

    // Random loads, boundary cycles included; the scoreboard checks each cycle.
    for (int k = 180; k <= 500; k++) begin
      wait_cyc(k);
      if ($urandom_range(0, 7) == 0) begin
        value    = 16'($urandom);
        digit_en = 4'($urandom);
        dp       = 4'($urandom);
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    wait_cyc(501);
    load = 1'b0;

    // Reset during slot idx=2 with a pending load.
    wait_cyc(520); drive_load(16'h1111, 4'b1111, 4'b1111);
    wait_cyc(522); check("pre_rst_an", an, 4'b1011);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 7'b1111111, 1'b1, 4'b1111);
    check("async_rst_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      wait_cyc(k);
      check("post_rst_fd", frame_done, (k == 16) || (k == 32));
      check("post_rst_seg", seg, 7'b1111111);
      if (k == 4) check("post_rst_an", an, 4'b1110);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
